// File: rtl/pipeline_memr_stage_p_if.sv
// Signal bundle between the memory-prepare stage, the memory-read stage and
// writeback, including the DRAM / sys_bus read-return paths.
//
// Handshake rules: both sides use valid/ready. A transfer happens on a rising
// clock edge where valid and ready are both high. Once valid is raised, it and
// its payload stay stable until that transfer happens. Ready may depend
// combinationally on the consumer's own state and on flush, never on valid.
interface pipeline_memr_stage_p_if #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
);
  // Upstream side (memory-prepare stage -> this stage)
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic                  is_dram_in;
  logic                  is_load_in;
  logic [2:0]            funct3_in;
  logic [XLEN-1:0]       pc_in;
  logic [1:0]            rf_wr_sel_in;
  logic                  rf_wr_en_in;
  logic [XLEN-1:0]       alu_result_in;
  logic [REG_ADDR_W-1:0] rd_in;

  // Read-return paths
  logic [XLEN-1:0]       dram_dout;
  logic                  dram_done;
  logic [XLEN-1:0]       sys_bus_dout;

  // Downstream side (this stage -> writeback)
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       mem_data_out;
  logic [XLEN-1:0]       pc_out;
  logic [1:0]            rf_wr_sel_out;
  logic                  rf_wr_en_out;
  logic [XLEN-1:0]       alu_result_out;
  logic [REG_ADDR_W-1:0] rd_out;
  logic                  timeout_err;

  // Debug view of the stage FSM (0 IDLE, 1 WAIT, 2 DRAIN)
  logic [1:0]            state_dbg;

  modport master (
    output flush, in_valid, is_dram_in, is_load_in, funct3_in, pc_in,
           rf_wr_sel_in, rf_wr_en_in, alu_result_in, rd_in,
           dram_dout, dram_done, sys_bus_dout, out_ready,
    input  in_ready, out_valid, mem_data_out, pc_out, rf_wr_sel_out,
           rf_wr_en_out, alu_result_out, rd_out, timeout_err, state_dbg
  );

  modport slave (
    input  flush, in_valid, is_dram_in, is_load_in, funct3_in, pc_in,
           rf_wr_sel_in, rf_wr_en_in, alu_result_in, rd_in,
           dram_dout, dram_done, sys_bus_dout, out_ready,
    output in_ready, out_valid, mem_data_out, pc_out, rf_wr_sel_out,
           rf_wr_en_out, alu_result_out, rd_out, timeout_err, state_dbg
  );
endinterface

// File: rtl/pipeline_memr_stage_p.sv
// Memory-read pipeline stage: accepts an instruction, waits in an FSM for a
// multi-cycle DRAM read if needed, extracts/extends the loaded sub-word and
// presents the result with sideband to writeback. A DRAM that never answers
// is abandoned after TIMEOUT_CYCLES and flagged with a sticky error; the
// stage then drains the late done so it is not credited to the next load.
module pipeline_memr_stage_p #(
  parameter int XLEN           = 64,
  parameter int REG_ADDR_W     = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_memr_stage_p_if.slave  bus
);
  localparam int OFF_W = $clog2(XLEN / 8);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  out_valid_q;
  logic                  timeout_err_q;
  logic [XLEN-1:0]       mem_data_q;
  logic [XLEN-1:0]       pc_q;
  logic [1:0]            rf_wr_sel_q;
  logic                  rf_wr_en_q;
  logic [XLEN-1:0]       alu_q;
  logic [REG_ADDR_W-1:0] rd_q;

  // Sideband held while the DRAM read is outstanding
  logic [2:0]            f3_h_q;
  logic [XLEN-1:0]       pc_h_q;
  logic [1:0]            sel_h_q;
  logic                  wen_h_q;
  logic [XLEN-1:0]       alu_h_q;
  logic [REG_ADDR_W-1:0] rd_h_q;

  logic                  in_ready;
  logic                  accept;
  logic [XLEN-1:0]       raw_now;
  logic [XLEN-1:0]       data_now;
  logic [XLEN-1:0]       data_held;

  // Shift the addressed byte down to bit 0, then size and extend it.
  // Bytes above the read word shift in as zero; misalignment is not trapped.
  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0]  raw,
                                              input logic [2:0]       f3,
                                              input logic [OFF_W-1:0] off);
    logic [XLEN-1:0] w;
    logic [XLEN-1:0] m8;
    logic [XLEN-1:0] m16;
    logic [XLEN-1:0] m32;
    w   = raw >> {off, 3'b000};
    m8  = XLEN'(8'hFF);
    m16 = XLEN'(16'hFFFF);
    m32 = XLEN'(32'hFFFF_FFFF);
    case (f3)
      3'b000:  extract = (w & m8)  | (w[7]  ? ~m8  : '0);
      3'b001:  extract = (w & m16) | (w[15] ? ~m16 : '0);
      3'b010:  extract = (w & m32) | (w[31] ? ~m32 : '0);
      3'b100:  extract = w & m8;
      3'b101:  extract = w & m16;
      3'b110:  extract = w & m32;
      default: extract = w;  // LD, or unsupported size: pass shifted word
    endcase
  endfunction

  // Upstream handshake and load data for the single-cycle completion path
  always_comb begin
    in_ready  = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready) && !bus.flush;
    accept    = bus.in_valid && in_ready;
    raw_now   = bus.is_dram_in ? bus.dram_dout : bus.sys_bus_dout;
    data_now  = bus.is_load_in
              ? extract(raw_now, bus.funct3_in, bus.alu_result_in[OFF_W-1:0])
              : '0;
    data_held = extract(bus.dram_dout, f3_h_q, alu_h_q[OFF_W-1:0]);
  end

  // Stage FSM with registered outputs, holding registers and timeout counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      mem_data_q    <= '0;
      pc_q          <= '0;
      rf_wr_sel_q   <= '0;
      rf_wr_en_q    <= 1'b0;
      alu_q         <= '0;
      rd_q          <= '0;
      f3_h_q        <= '0;
      pc_h_q        <= '0;
      sel_h_q       <= '0;
      wen_h_q       <= 1'b0;
      alu_h_q       <= '0;
      rd_h_q        <= '0;
    end else begin
      // Consumed result retires unless overwritten below on the same edge
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;

      if (bus.flush) begin
        out_valid_q <= 1'b0;
        // A done arriving with the flush already closes the read
        if (state_q == S_WAIT) state_q <= bus.dram_done ? S_IDLE : S_DRAIN;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              if (bus.is_load_in && bus.is_dram_in && !bus.dram_done) begin
                f3_h_q  <= bus.funct3_in;
                pc_h_q  <= bus.pc_in;
                sel_h_q <= bus.rf_wr_sel_in;
                wen_h_q <= bus.rf_wr_en_in;
                alu_h_q <= bus.alu_result_in;
                rd_h_q  <= bus.rd_in;
                cnt_q   <= '0;
                state_q <= S_WAIT;
              end else begin
                mem_data_q  <= data_now;
                pc_q        <= bus.pc_in;
                rf_wr_sel_q <= bus.rf_wr_sel_in;
                rf_wr_en_q  <= bus.rf_wr_en_in;
                alu_q       <= bus.alu_result_in;
                rd_q        <= bus.rd_in;
                out_valid_q <= 1'b1;
              end
            end
          end
          S_WAIT: begin
            if (bus.dram_done || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
              pc_q        <= pc_h_q;
              rf_wr_sel_q <= sel_h_q;
              alu_q       <= alu_h_q;
              rd_q        <= rd_h_q;
              out_valid_q <= 1'b1;
              if (bus.dram_done) begin
                mem_data_q <= data_held;
                rf_wr_en_q <= wen_h_q;
                state_q    <= S_IDLE;
              end else begin
                // Timed out: retire without a register write
                mem_data_q    <= '0;
                rf_wr_en_q    <= 1'b0;
                timeout_err_q <= 1'b1;
                state_q       <= S_DRAIN;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_DRAIN: begin
            if (bus.dram_done) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.mem_data_out   = mem_data_q;
  assign bus.pc_out         = pc_q;
  assign bus.rf_wr_sel_out  = rf_wr_sel_q;
  assign bus.rf_wr_en_out   = rf_wr_en_q;
  assign bus.alu_result_out = alu_q;
  assign bus.rd_out         = rd_q;
  assign bus.timeout_err    = timeout_err_q;
  assign bus.state_dbg      = state_q;
endmodule

// File: tb/tb_pipeline_memr_stage_p.sv
// Directed bench for the memory-read stage (XLEN=64, TIMEOUT_CYCLES=4).
// Inputs change 1 ns after a rising edge; outputs are checked there too.
module tb_pipeline_memr_stage_p;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  pipeline_memr_stage_p_if #(.XLEN(64), .REG_ADDR_W(5)) bus ();

  pipeline_memr_stage_p #(
    .XLEN(64), .REG_ADDR_W(5), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.flush         = 1'b0;
    bus.in_valid      = 1'b0;
    bus.is_dram_in    = 1'b0;
    bus.is_load_in    = 1'b0;
    bus.funct3_in     = 3'b000;
    bus.pc_in         = '0;
    bus.rf_wr_sel_in  = 2'b00;
    bus.rf_wr_en_in   = 1'b0;
    bus.alu_result_in = '0;
    bus.rd_in         = '0;
    bus.dram_dout     = '0;
    bus.dram_done     = 1'b0;
    bus.sys_bus_dout  = '0;
    bus.out_ready     = 1'b1;
  endtask

  // Present one instruction for a single cycle
  task automatic send(input logic dram, input logic load, input logic [2:0] f3,
                      input logic [63:0] pc, input logic [63:0] alu, input logic [4:0] rd);
    bus.in_valid      = 1'b1;
    bus.is_dram_in    = dram;
    bus.is_load_in    = load;
    bus.funct3_in     = f3;
    bus.pc_in         = pc;
    bus.rf_wr_sel_in  = 2'b01;
    bus.rf_wr_en_in   = 1'b1;
    bus.alu_result_in = alu;
    bus.rd_in         = rd;
    tick();
    bus.in_valid      = 1'b0;
  endtask

  // Single-cycle load (sys_bus, or DRAM with done on the accept cycle)
  task automatic load_vec(input string tag, input logic dram, input logic [2:0] f3,
                          input logic [63:0] alu, input logic [63:0] raw,
                          input logic [63:0] exp);
    bus.dram_dout    = dram ? raw : 64'h0;
    bus.dram_done    = dram;
    bus.sys_bus_dout = dram ? 64'h0 : raw;
    send(dram, 1'b1, f3, 64'h2000, alu, 5'd7);
    bus.dram_done    = 1'b0;
    check({tag, "_valid"}, 64'(bus.out_valid), 64'h1);
    check({tag, "_data"}, bus.mem_data_out, exp);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    drive_idle();
    #3;
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    check("rst_timeout_err", 64'(bus.timeout_err), 64'h0);
    check("rst_mem_data", bus.mem_data_out, 64'h0);
    check("rst_state", 64'(bus.state_dbg), 64'h0);
    check("rst_in_ready", 64'(bus.in_ready), 64'h1);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // ALU passthrough
    send(1'b0, 1'b0, 3'b000, 64'h1000, 64'h55, 5'd3);
    check("alu_valid", 64'(bus.out_valid), 64'h1);
    check("alu_result", bus.alu_result_out, 64'h55);
    check("alu_pc", bus.pc_out, 64'h1000);
    check("alu_rd", 64'(bus.rd_out), 64'h3);
    check("alu_mem_data", bus.mem_data_out, 64'h0);
    check("alu_in_ready", 64'(bus.in_ready), 64'h1);
    tick();
    check("alu_retired", 64'(bus.out_valid), 64'h0);

    // DRAM LB at offset 3, done three cycles after accept
    bus.dram_dout = 64'h0000_0000_80FF_0000;
    send(1'b1, 1'b1, 3'b000, 64'h1100, 64'h3, 5'd4);
    check("lb_wait_ready", 64'(bus.in_ready), 64'h0);
    check("lb_wait_state", 64'(bus.state_dbg), 64'h1);
    tick();
    check("lb_wait_ready2", 64'(bus.in_ready), 64'h0);
    tick();
    check("lb_wait_valid", 64'(bus.out_valid), 64'h0);
    bus.dram_done = 1'b1;
    tick();
    bus.dram_done = 1'b0;
    check("lb_valid", 64'(bus.out_valid), 64'h1);
    check("lb_data", bus.mem_data_out, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_rd", 64'(bus.rd_out), 64'h4);
    check("lb_state", 64'(bus.state_dbg), 64'h0);
    tick();

    // Sub-word extraction, back to back
    load_vec("lhu",  1'b0, 3'b101, 64'h0, 64'h1234_5678_9ABC_8001, 64'h0000_0000_0000_8001);
    load_vec("lb",   1'b0, 3'b000, 64'h1, 64'h0000_0000_0000_7F00, 64'h0000_0000_0000_007F);
    load_vec("lbu",  1'b0, 3'b100, 64'h7, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB);
    load_vec("lh",   1'b0, 3'b001, 64'h6, 64'hFFFE_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE);
    load_vec("lw",   1'b0, 3'b010, 64'h4, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001);
    load_vec("lwu",  1'b0, 3'b110, 64'h4, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001);
    load_vec("ld",   1'b1, 3'b011, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    load_vec("f3_7", 1'b0, 3'b111, 64'h2, 64'h0123_4567_89AB_CDEF, 64'h0000_0123_4567_89AB);
    tick();
    check("vec_retired", 64'(bus.out_valid), 64'h0);

    // Backpressure
    bus.out_ready = 1'b0;
    send(1'b0, 1'b0, 3'b000, 64'h1200, 64'hA1, 5'd5);
    check("bp_first", bus.alu_result_out, 64'hA1);
    bus.in_valid      = 1'b1;
    bus.alu_result_in = 64'hB2;
    #1;
    check("bp_in_ready_low", 64'(bus.in_ready), 64'h0);
    tick();
    check("bp_held_valid", 64'(bus.out_valid), 64'h1);
    check("bp_held_data", bus.alu_result_out, 64'hA1);
    bus.out_ready = 1'b1;
    #1;
    check("bp_in_ready_high", 64'(bus.in_ready), 64'h1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_replaced_valid", 64'(bus.out_valid), 64'h1);
    check("bp_replaced_data", bus.alu_result_out, 64'hB2);
    tick();
    check("bp_retired", 64'(bus.out_valid), 64'h0);

    // Timeout after four WAIT cycles, then late done drains
    send(1'b1, 1'b1, 3'b011, 64'h1300, 64'h8, 5'd6);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_waiting", 64'(bus.out_valid), 64'h0);
    end
    tick();
    check("to_valid", 64'(bus.out_valid), 64'h1);
    check("to_wr_en", 64'(bus.rf_wr_en_out), 64'h0);
    check("to_data", bus.mem_data_out, 64'h0);
    check("to_err", 64'(bus.timeout_err), 64'h1);
    check("to_state", 64'(bus.state_dbg), 64'h2);
    tick();
    check("drain_state", 64'(bus.state_dbg), 64'h2);
    check("drain_in_ready", 64'(bus.in_ready), 64'h0);
    bus.dram_done = 1'b1;
    tick();
    bus.dram_done = 1'b0;
    check("drain_to_idle", 64'(bus.state_dbg), 64'h0);
    check("drain_err_sticky", 64'(bus.timeout_err), 64'h1);

    // Flush in WAIT, late done, then a fresh load waits for its own done
    bus.dram_dout = 64'h77;
    send(1'b1, 1'b1, 3'b000, 64'h1400, 64'h10, 5'd8);
    tick();
    bus.flush = 1'b1;
    #1;
    check("fl_in_ready", 64'(bus.in_ready), 64'h0);
    tick();
    bus.flush = 1'b0;
    check("fl_state", 64'(bus.state_dbg), 64'h2);
    check("fl_valid", 64'(bus.out_valid), 64'h0);
    tick();
    bus.dram_done = 1'b1;
    tick();
    bus.dram_done = 1'b0;
    check("fl_idle", 64'(bus.state_dbg), 64'h0);
    check("fl_no_output", 64'(bus.out_valid), 64'h0);
    bus.dram_dout = 64'h5A;
    send(1'b1, 1'b1, 3'b100, 64'h3000, 64'h40, 5'd9);
    check("fl_next_wait", 64'(bus.state_dbg), 64'h1);
    check("fl_next_valid", 64'(bus.out_valid), 64'h0);
    tick();
    bus.dram_done = 1'b1;
    tick();
    bus.dram_done = 1'b0;
    check("fl_next_data", bus.mem_data_out, 64'h5A);
    check("fl_next_done", 64'(bus.out_valid), 64'h1);

    // Flush drops a held result
    bus.out_ready = 1'b0;
    bus.flush     = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    check("fl_out_cleared", 64'(bus.out_valid), 64'h0);
    check("fl_err_kept", 64'(bus.timeout_err), 64'h1);

    // Asynchronous reset in the middle of WAIT
    send(1'b1, 1'b1, 3'b000, 64'h3100, 64'h48, 5'd10);
    tick();
    check("rw_state", 64'(bus.state_dbg), 64'h1);
    #2;
    reset = 1'b0;
    #1;
    check("rw_state_rst", 64'(bus.state_dbg), 64'h0);
    check("rw_err_rst", 64'(bus.timeout_err), 64'h0);
    check("rw_alu_rst", bus.alu_result_out, 64'h0);
    check("rw_pc_rst", bus.pc_out, 64'h0);
    check("rw_valid_rst", 64'(bus.out_valid), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
